// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK register write path: FSM states, op codes
// and the per-bit minimal-drive excitation function.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } jk_state_e;

  localparam logic JK_OP_LOAD   = 1'b0;
  localparam logic JK_OP_TOGGLE = 1'b1;

  // Returns {J, K} for one bit: set a 0 that must become 1, clear a 1 that must
  // become 0, leave bits that already match undriven.
  function automatic logic [1:0] jk_excite(input logic t, input logic q);
    jk_excite = {t & ~q, ~t & q};
  endfunction

endpackage

// File: rtl/jk_bank.sv
// Array of WIDTH JK flip-flops sharing clk/rst; Q clears to 0 on reset.
module jk_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  // JK characteristic equation: Q+ = J.~Q | ~K.Q (hold, reset, set, toggle).
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule

// File: rtl/jk_write_ctrl.sv
// Write controller that turns LOAD/TOGGLE requests into one-cycle J/K drives on a
// jk_bank, with optional readback/retry when JK_WRITE_SELF_CHECK_EN is defined.
module jk_write_ctrl
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] jk_q,
  output logic             busy,
  output logic             resp_valid,
  output logic             resp_err
);

  jk_state_e        state, state_nxt;
  logic [WIDTH-1:0] tgt, tgt_nxt;
  logic [WIDTH-1:0] j_nxt, k_nxt;
  logic [WIDTH-1:0] ex_t, ex_j, ex_k;
  logic             hs;
  logic             resp_c;
  logic             err_c;
  logic             retry_inc;

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE) && !rst;
  assign hs        = req_valid && req_ready;

  // Excitation source: the incoming LOAD value on acceptance, the held target on retry.
  assign ex_t = (state == IDLE) ? req_data : tgt;

  always_comb begin
    ex_j = '0;
    ex_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {ex_j[i], ex_k[i]} = jk_excite(ex_t[i], jk_q[i]);
    end
  end

`ifdef JK_WRITE_SELF_CHECK_EN
  localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

  logic [3:0] retry_cnt;
  logic       match;

  assign match = (jk_q == tgt);

  always_ff @(posedge clk) begin
    if (rst || hs) begin
      retry_cnt <= '0;
    end else if (retry_inc) begin
      retry_cnt <= retry_cnt + 4'd1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    j_nxt     = '0;
    k_nxt     = '0;
    resp_c    = 1'b0;
    err_c     = 1'b0;
    retry_inc = 1'b0;
    case (state)
      IDLE: begin
        if (hs) begin
          state_nxt = DRIVE;
          if (req_op == JK_OP_TOGGLE) begin
            tgt_nxt = jk_q ^ req_data;
            j_nxt   = req_data;
            k_nxt   = req_data;
          end else begin
            tgt_nxt = req_data;
            j_nxt   = ex_j;
            k_nxt   = ex_k;
          end
        end
      end
      DRIVE: begin
        state_nxt = CHECK;
      end
      CHECK: begin
`ifdef JK_WRITE_SELF_CHECK_EN
        if (match) begin
          resp_c    = 1'b1;
          state_nxt = IDLE;
        end else if (retry_cnt < MAX_RETRY_C) begin
          // Retries re-drive as a LOAD against the live Q, whatever the original op.
          retry_inc = 1'b1;
          j_nxt     = ex_j;
          k_nxt     = ex_k;
          state_nxt = DRIVE;
        end else begin
          resp_c    = 1'b1;
          err_c     = 1'b1;
          state_nxt = IDLE;
        end
`else
        resp_c    = 1'b1;
        state_nxt = IDLE;
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign resp_valid = resp_c && !rst;
  assign resp_err   = err_c && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      jk_j  <= '0;
      jk_k  <= '0;
    end else begin
      state <= state_nxt;
      jk_j  <= j_nxt;
      jk_k  <= k_nxt;
    end
  end

  always_ff @(posedge clk) begin
    tgt <= tgt_nxt;
  end

endmodule

// File: doc/jk_write_ctrl.md
# jk_write_ctrl

Write-side controller for a bank of JK flip-flops: it accepts a requested register value or toggle mask over a valid/ready handshake. It translates the request into per-bit J/K excitation against the bank's live Q. It drives the bank for one cycle and, optionally, reads back and retries. It sits between a configuration/request master and a `jk_bank` register array, so JK storage can be written like an ordinary register.

## Interface
- `WIDTH`, 8: number of JK bits in the bank.
- `MAX_RETRY`, 2: extra drive attempts after a failed readback (0..15).

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; transfer when `req_valid && req_ready`.
- `req_op`  in  1  0 = LOAD (`req_data` is target value), 1 = TOGGLE (`req_data` is toggle mask).
- `req_data`  in  WIDTH  target value or toggle mask.
- `jk_j`  out  WIDTH  J drive to bank.
- `jk_k`  out  WIDTH  K drive to bank.
- `jk_q`  in  WIDTH  bank Q readback.
- `busy`  out  1  high in any state other than IDLE.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  valid with `resp_valid`; 1 = target not reached after all retries.

## Operation
- States: IDLE, DRIVE, CHECK.
- IDLE: `req_ready`=1. On handshake, capture the target and the op, clear the retry counter, and go to DRIVE. LOAD target = `req_data`. TOGGLE target = `jk_q ^ req_data`, sampled in the handshake cycle.
- DRIVE, first attempt:
  - LOAD: `jk_j = t & ~jk_q`, `jk_k = ~t & jk_q`. Minimal drive: only bits that change are driven.
  - TOGGLE: `jk_j = jk_k = mask`.
  - Next state is CHECK.
- DRIVE, retry attempts always use the LOAD excitation against the current `jk_q`, whatever the original op was.
- CHECK:
  - `jk_q == t`: pulse `resp_valid` with `resp_err`=0, go to IDLE.
  - Mismatch and retry count < `MAX_RETRY`: increment the count, go to DRIVE.
  - Mismatch and retry count = `MAX_RETRY`: pulse `resp_valid` with `resp_err`=1, go to IDLE.
- `jk_j` and `jk_k` are 0 in every state except DRIVE, so the bank holds.
- `req_valid` is ignored while `busy`. The request is not queued.
- Reset (any state, including mid-DRIVE or mid-CHECK):
  - Next state is IDLE. `jk_j`, `jk_k`, `resp_valid`, `resp_err` and the retry count all go to 0.
  - Any in-flight request is dropped with no response.
  - `req_ready`=0 and `busy`=0 while `rst` is high.

## Timing
- Handshake in cycle T, DRIVE in T+1; the bank updates at the end of T+1.
- CHECK and `resp_valid` in T+2 on a first-pass match.
- Each retry adds 2 cycles. Worst case `resp_valid` at T+2+2·`MAX_RETRY`.
- `req_ready` rises in T+3 after a first-pass match. Maximum throughput is one request per 3 cycles.
- `jk_j`/`jk_k` are registered, so they are stable for the whole DRIVE cycle.

## Configuration
- `JK_WRITE_SELF_CHECK_EN` defined:
  - CHECK compares readback as described above and retries on mismatch.
  - `resp_err` is meaningful.
- `JK_WRITE_SELF_CHECK_EN` undefined:
  - CHECK does no comparison and always responds `resp_valid` in T+2.
  - `resp_err` is tied to 0 and the retry counter is not built.
  - Handshake and drive timing are identical in both builds.

## Structure
- Package `jk_pkg` holds:
  - the state enum (IDLE, DRIVE, CHECK);
  - op constants `JK_OP_LOAD` = 0 and `JK_OP_TOGGLE` = 1;
  - a combinational function `jk_excite(t, q)` that returns {J, K} using the minimal-drive rule.
- Sub-module `jk_bank` contains `WIDTH` JK flip-flops that share `clk`/`rst` (reset Q=0). It is instantiated by the top level and the bench, not inside `jk_write_ctrl`.

## Test plan
All scenarios use `WIDTH`=8, `MAX_RETRY`=2 and `JK_WRITE_SELF_CHECK_EN` defined.
- Reset, then LOAD 0xA5 from Q=0x00 → DRIVE `jk_j`=0xA5, `jk_k`=0x00; `resp_valid`@T+2, `resp_err`=0; Q=0xA5.
- LOAD 0x0F from Q=0xA5 → `jk_j`=0x0A, `jk_k`=0xA0; Q=0x0F, `resp_err`=0.
- TOGGLE 0xFF from Q=0x0F → `jk_j`=`jk_k`=0xFF; Q=0xF0; `resp_valid`@T+2.
- Bank bit0 forced stuck-at-0, LOAD 0x01 → DRIVE in T+1, T+3 and T+5 with `jk_j`=0x01; `resp_valid`@T+6 with `resp_err`=1. Repeat without the macro → `resp_valid`@T+2, `resp_err`=0.
- `rst` pulsed in the CHECK cycle → no `resp_valid`, `jk_j`/`jk_k`=0, `req_ready`=1 the cycle after `rst` falls.
- `req_valid` held high across two requests → the second is accepted at T+3, never earlier; `busy`=1 in T+1..T+2.
